// File: rtl/cam_frame_capture_pkg.sv
// Shared camera package: capture FSM encodings, default frame geometry and
// the saturating counter helper used by the line/pixel counters.
package cam_frame_capture_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_SKIP_FRAMES = 2;

    localparam int         CNT_W   = 11;
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SKIP     = 2'd1,
        CAPTURE  = 2'd2
    } cap_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 11'd1;
    endfunction

endpackage

// File: rtl/cam_frame_capture_sync.sv
// Two-flop synchroniser bringing a slow asynchronous level into cmos_pclk.
module sync_2ff (
    input  logic cmos_pclk,
    input  logic rst_133,
    input  logic din,
    output logic sync_out
);

    logic stage1;

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            stage1   <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            stage1   <= din;
            sync_out <= stage1;
        end
    end

endmodule

// File: rtl/cam_frame_capture.sv
// Camera capture front end: packs CMOS byte pairs into RGB565 words, drops
// the first frames after configuration and flags malformed lines/frames.
module cam_frame_capture
    import cam_frame_capture_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES
) (
    input  logic        cmos_pclk,
    input  logic        rst_133,
    input  logic        cfg_done,
    input  logic        cmos_vsyn,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic [15:0] data_16b,
    output logic        data_16b_en,
    output logic        frame_start,
    output logic        bank_switch,
    output logic [10:0] pix_cnt,
    output logic [10:0] line_cnt,
    output logic [2:0]  err_flags
);

    localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
    localparam logic [7:0]  SKIP_LIM = 8'(SKIP_FRAMES);

    cap_state_t  state;
    cap_state_t  next_state;
    logic        cfg_sync;
    logic        vs_d1;
    logic        vs_d2;
    logic        vs_rise;
    logic        href_q;
    logic        href_fall;
    logic        byte_phase;
    logic [7:0]  high_byte;
    logic [7:0]  skip_cnt;
    logic        frame_pulse;
    logic        word_ok;

    sync_2ff u_sync_cfg (
        .cmos_pclk (cmos_pclk),
        .rst_133   (rst_133),
        .din       (cfg_done),
        .sync_out  (cfg_sync)
    );

    sync_2ff u_sync_vs (
        .cmos_pclk (cmos_pclk),
        .rst_133   (rst_133),
        .din       (cmos_vsyn),
        .sync_out  (vs_d1)
    );

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            vs_d2  <= 1'b0;
            href_q <= 1'b0;
        end else begin
            vs_d2  <= vs_d1;
            href_q <= cmos_href;
        end
    end

    assign vs_rise   = vs_d1 & ~vs_d2;
    assign href_fall = href_q & ~cmos_href;

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            state <= WAIT_CFG;
        end else begin
            state <= next_state;
        end
    end

    // Losing configuration always wins, whatever state the capture is in.
    always_comb begin
        next_state  = state;
        frame_pulse = 1'b0;
        if (!cfg_sync) begin
            next_state = WAIT_CFG;
        end else begin
            case (state)
                WAIT_CFG: next_state = SKIP;
                SKIP: begin
                    if (vs_rise && (skip_cnt == SKIP_LIM)) begin
                        next_state  = CAPTURE;
                        frame_pulse = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_pulse = 1'b1;
                    end
                end
                default: next_state = WAIT_CFG;
            endcase
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            skip_cnt <= 8'd0;
        end else if (state != SKIP) begin
            skip_cnt <= 8'd0;
        end else if (vs_rise && (skip_cnt != SKIP_LIM)) begin
            skip_cnt <= skip_cnt + 8'd1;
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            frame_start <= 1'b0;
            bank_switch <= 1'b0;
        end else begin
            frame_start <= frame_pulse;
            if (frame_start) begin
                bank_switch <= ~bank_switch;
            end
        end
    end

    assign word_ok = (state == CAPTURE) && (pix_cnt < H_LIM) && (line_cnt < V_LIM);

    // vs_rise outranks the line logic: a frame boundary discards whatever
    // line was in flight without judging its length.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            data_16b    <= 16'h0000;
            data_16b_en <= 1'b0;
            high_byte   <= 8'h00;
            byte_phase  <= 1'b0;
            pix_cnt     <= 11'd0;
            line_cnt    <= 11'd0;
            err_flags   <= 3'b000;
        end else begin
            data_16b_en <= 1'b0;
            if (!cfg_sync) begin
                byte_phase <= 1'b0;
                pix_cnt    <= 11'd0;
                line_cnt   <= 11'd0;
            end else if (vs_rise) begin
                if ((state == CAPTURE) && (line_cnt != V_LIM)) begin
                    err_flags[2] <= 1'b1;
                end
                byte_phase <= 1'b0;
                pix_cnt    <= 11'd0;
                line_cnt   <= 11'd0;
            end else begin
                if (href_fall) begin
                    line_cnt <= sat_inc(line_cnt);
                    pix_cnt  <= 11'd0;
                    if (state == CAPTURE) begin
                        if (pix_cnt != H_LIM) begin
                            err_flags[0] <= 1'b1;
                        end
                        if (byte_phase) begin
                            err_flags[1] <= 1'b1;
                        end
                    end
                end
                if (cmos_href) begin
                    byte_phase <= ~byte_phase;
                    if (!byte_phase) begin
                        high_byte <= cmos_data;
                    end else begin
                        pix_cnt <= sat_inc(pix_cnt);
                        if (word_ok) begin
                            data_16b    <= {high_byte, cmos_data};
                            data_16b_en <= 1'b1;
                        end
                    end
                end else begin
                    byte_phase <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture with a small frame geometry.
module tb_cam_frame_capture;
    import cam_frame_capture_pkg::*;

    typedef struct {
        logic        href;
        logic [7:0]  data;
        logic        exp_en;
        logic [15:0] exp_data;
        logic [10:0] exp_pix;
        logic [10:0] exp_line;
    } vec_t;

    logic        cmos_pclk = 1'b0;
    logic        rst_133   = 1'b0;
    logic        cfg_done  = 1'b0;
    logic        cmos_vsyn = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = 8'h00;
    logic [15:0] data_16b;
    logic        data_16b_en;
    logic        frame_start;
    logic        bank_switch;
    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;
    logic [2:0]  err_flags;

    int check_cnt  = 0;
    int pass_cnt   = 0;
    int strobe_cnt = 0;
    int fs_cnt     = 0;

    vec_t vecs [19];

    cam_frame_capture #(
        .H_ACTIVE    (4),
        .V_ACTIVE    (2),
        .SKIP_FRAMES (2)
    ) dut (
        .cmos_pclk   (cmos_pclk),
        .rst_133     (rst_133),
        .cfg_done    (cfg_done),
        .cmos_vsyn   (cmos_vsyn),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .data_16b    (data_16b),
        .data_16b_en (data_16b_en),
        .frame_start (frame_start),
        .bank_switch (bank_switch),
        .pix_cnt     (pix_cnt),
        .line_cnt    (line_cnt),
        .err_flags   (err_flags)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    always @(posedge cmos_pclk) begin
        #1;
        if (data_16b_en === 1'b1) strobe_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic href, input logic [7:0] data);
        @(negedge cmos_pclk);
        cmos_href = href;
        cmos_data = data;
        @(posedge cmos_pclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic vsyncPulse();
        cmos_vsyn = 1'b1;
        idle(4);
        cmos_vsyn = 1'b0;
        idle(4);
    endtask

    task automatic sendLine(input int nbytes, input logic [7:0] base);
        for (int i = 0; i < nbytes; i++) applyStimulus(1'b1, base + 8'(i));
        idle(2);
    endtask

    initial begin
        int s0;
        int f0;

        vecs[0]  = '{1'b1, 8'hF8, 1'b0, 16'h0000, 11'd0, 11'd0};
        vecs[1]  = '{1'b1, 8'h1F, 1'b1, 16'hF81F, 11'd1, 11'd0};
        vecs[2]  = '{1'b1, 8'h07, 1'b0, 16'h0000, 11'd1, 11'd0};
        vecs[3]  = '{1'b1, 8'hE0, 1'b1, 16'h07E0, 11'd2, 11'd0};
        vecs[4]  = '{1'b1, 8'h12, 1'b0, 16'h0000, 11'd2, 11'd0};
        vecs[5]  = '{1'b1, 8'h34, 1'b1, 16'h1234, 11'd3, 11'd0};
        vecs[6]  = '{1'b1, 8'h56, 1'b0, 16'h0000, 11'd3, 11'd0};
        vecs[7]  = '{1'b1, 8'h78, 1'b1, 16'h5678, 11'd4, 11'd0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 11'd0, 11'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 11'd0, 11'd1};
        vecs[10] = '{1'b1, 8'hAB, 1'b0, 16'h0000, 11'd0, 11'd1};
        vecs[11] = '{1'b1, 8'hCD, 1'b1, 16'hABCD, 11'd1, 11'd1};
        vecs[12] = '{1'b1, 8'h00, 1'b0, 16'h0000, 11'd1, 11'd1};
        vecs[13] = '{1'b1, 8'hFF, 1'b1, 16'h00FF, 11'd2, 11'd1};
        vecs[14] = '{1'b1, 8'h5A, 1'b0, 16'h0000, 11'd2, 11'd1};
        vecs[15] = '{1'b1, 8'hA5, 1'b1, 16'h5AA5, 11'd3, 11'd1};
        vecs[16] = '{1'b1, 8'hC3, 1'b0, 16'h0000, 11'd3, 11'd1};
        vecs[17] = '{1'b1, 8'h3C, 1'b1, 16'hC33C, 11'd4, 11'd1};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 16'h0000, 11'd0, 11'd2};

        $display("[TB] reset state");
        idle(3);
        checkOutput("rst_data_16b", data_16b, 0);
        checkOutput("rst_data_en", data_16b_en, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_bank", bank_switch, 0);
        checkOutput("rst_pix", pix_cnt, 0);
        checkOutput("rst_line", line_cnt, 0);
        checkOutput("rst_err", err_flags, 0);
        @(negedge cmos_pclk);
        rst_133 = 1'b1;

        $display("[TB] skip sequence");
        cfg_done = 1'b1;
        idle(5);
        f0 = fs_cnt;
        vsyncPulse();
        checkOutput("skip_pulse1_fs", fs_cnt - f0, 0);
        vsyncPulse();
        checkOutput("skip_pulse2_fs", fs_cnt - f0, 0);
        checkOutput("skip_bank_before", bank_switch, 0);
        vsyncPulse();
        checkOutput("skip_pulse3_fs", fs_cnt - f0, 1);
        checkOutput("skip_bank_after", bank_switch, 1);

        $display("[TB] good frame table");
        s0 = strobe_cnt;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].href, vecs[i].data);
            checkOutput($sformatf("vec%0d_en", i), data_16b_en, vecs[i].exp_en);
            if (vecs[i].exp_en) begin
                checkOutput($sformatf("vec%0d_data", i), data_16b, vecs[i].exp_data);
            end
            checkOutput($sformatf("vec%0d_pix", i), pix_cnt, vecs[i].exp_pix);
            checkOutput($sformatf("vec%0d_line", i), line_cnt, vecs[i].exp_line);
        end
        checkOutput("good_strobes", strobe_cnt - s0, 8);
        checkOutput("good_err_line", err_flags, 0);
        f0 = fs_cnt;
        vsyncPulse();
        checkOutput("good_next_fs", fs_cnt - f0, 1);
        checkOutput("good_bank", bank_switch, 0);
        checkOutput("good_err_frame", err_flags, 0);
        checkOutput("good_line_cleared", line_cnt, 0);

        $display("[TB] malformed frame");
        s0 = strobe_cnt;
        sendLine(11, 8'h40);
        checkOutput("long_odd_strobes", strobe_cnt - s0, 4);
        checkOutput("long_odd_err", err_flags, 3);
        s0 = strobe_cnt;
        sendLine(8, 8'h60);
        checkOutput("line2_strobes", strobe_cnt - s0, 4);
        s0 = strobe_cnt;
        sendLine(8, 8'h70);
        checkOutput("line3_strobes", strobe_cnt - s0, 0);
        checkOutput("line3_count", line_cnt, 3);
        checkOutput("line3_err", err_flags, 3);
        vsyncPulse();
        checkOutput("frame_err", err_flags, 7);
        checkOutput("frame_bank", bank_switch, 1);

        $display("[TB] cfg_done loss mid-line");
        s0 = strobe_cnt;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h80 + 8'(i));
        checkOutput("cfg_pre_strobes", strobe_cnt - s0, 2);
        cfg_done = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h90 + 8'(i));
        checkOutput("cfg_pix_cleared", pix_cnt, 0);
        checkOutput("cfg_state", int'(dut.state), int'(WAIT_CFG));
        s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hA0 + 8'(i));
        checkOutput("cfg_no_strobes", strobe_cnt - s0, 0);
        checkOutput("cfg_pix_held", pix_cnt, 0);
        idle(2);

        $display("[TB] asynchronous reset mid-line");
        cfg_done = 1'b1;
        idle(5);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        applyStimulus(1'b1, 8'h33);
        #2;
        rst_133 = 1'b0;
        #1;
        checkOutput("arst_data_16b", data_16b, 0);
        checkOutput("arst_data_en", data_16b_en, 0);
        checkOutput("arst_frame_start", frame_start, 0);
        checkOutput("arst_bank", bank_switch, 0);
        checkOutput("arst_pix", pix_cnt, 0);
        checkOutput("arst_line", line_cnt, 0);
        checkOutput("arst_err", err_flags, 0);
        checkOutput("arst_state", int'(dut.state), int'(WAIT_CFG));
        @(negedge cmos_pclk);
        cmos_href = 1'b0;
        rst_133   = 1'b1;
        idle(5);
        f0 = fs_cnt;
        s0 = strobe_cnt;
        vsyncPulse();
        vsyncPulse();
        checkOutput("rerun_pulse2_fs", fs_cnt - f0, 0);
        vsyncPulse();
        checkOutput("rerun_pulse3_fs", fs_cnt - f0, 1);
        checkOutput("rerun_bank", bank_switch, 1);
        checkOutput("rerun_no_strobes", strobe_cnt - s0, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
